// File: rtl/exu_iexec_req_fifo.sv
// Purpose: instruction-execute request queue; buffers {pc, ir} from fetch and presents the oldest entry to the EXU.
// Latency: one cycle from push to iexec_req_vld (no bypass); head is read straight from storage.
// Backpressure: in_rdy drops when full or on flush/reset; the head is held stable until the EXU accepts it or a flush occurs.
module exu_iexec_req_fifo #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [31:0]              in_ir,
    output logic                     iexec_req_vld,
    input  logic                     iexec_req_rdy,
    output logic [XLEN-1:0]          iexec_req_pc,
    output logic [31:0]              iexec_req_ir,
    output logic [6:0]               iexec_req_opcode,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [AW:0] DEPTH_P = DEPTH[AW:0];

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     ir;
    } entry_t;

    entry_t      mem [DEPTH];
    entry_t      head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Ready/valid are gated by reset and flush only, never by the opposite side's handshake.
    assign in_rdy        = rst_n & ~flush & ~full;
    assign iexec_req_vld = rst_n & ~flush & ~empty;

    assign push = in_vld & in_rdy;
    assign pop  = iexec_req_vld & iexec_req_rdy;

    assign head             = mem[rd_ptr[AW-1:0]];
    assign iexec_req_pc     = head.pc;
    assign iexec_req_ir     = head.ir;
    assign iexec_req_opcode = head.ir[6:0];

    assign count = rst_n ? (wr_ptr - rd_ptr) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{pc: in_pc, ir: in_ir};
        end
    end

`ifndef SYNTHESIS
    logic   hold_q;
    entry_t head_q;

    always @(posedge clk) begin
        hold_q <= rst_n & iexec_req_vld & ~iexec_req_rdy & ~flush;
        head_q <= head;
        if (rst_n) begin
            assert (!(push && full));
            assert (!(pop && empty));
            assert (count <= DEPTH_P);
            if (hold_q && !flush) begin
                assert (iexec_req_vld && head == head_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_exu_iexec_req_fifo.sv
// Directed bench for exu_iexec_req_fifo (DEPTH=2): reset, single push, fill, streaming, hold, flush, mid-stream reset.
// Stimulus changes 1ns after the rising edge; outputs are sampled 1ns later.
// Fetch and EXU sides are driven directly by the bench; no random stalls.
module tb_exu_iexec_req_fifo;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_pc;
    logic [31:0] in_ir;
    logic        iexec_req_vld;
    logic        iexec_req_rdy;
    logic [31:0] iexec_req_pc;
    logic [31:0] iexec_req_ir;
    logic [6:0]  iexec_req_opcode;
    logic [1:0]  count;

    int errors = 0;
    int checks = 0;

    exu_iexec_req_fifo #(.DEPTH(2), .XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .in_vld           (in_vld),
        .in_rdy           (in_rdy),
        .in_pc            (in_pc),
        .in_ir            (in_ir),
        .iexec_req_vld    (iexec_req_vld),
        .iexec_req_rdy    (iexec_req_rdy),
        .iexec_req_pc     (iexec_req_pc),
        .iexec_req_ir     (iexec_req_ir),
        .iexec_req_opcode (iexec_req_opcode),
        .count            (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s", tag);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_vld = 1'b1; in_pc = 32'h0; in_ir = 32'h0; iexec_req_rdy = 1'b0;

        settle();
        chk("rst_in_rdy", in_rdy === 1'b0);
        chk("rst_vld", iexec_req_vld === 1'b0);
        chk("rst_count", count === 2'd0);
        tick(); tick();
        rst_n = 1'b1; in_vld = 1'b0;
        settle();
        chk("post_rst_in_rdy", in_rdy === 1'b1);
        chk("post_rst_vld", iexec_req_vld === 1'b0);

        in_vld = 1'b1; in_pc = 32'h8000_0000; in_ir = 32'h0000_10B7; iexec_req_rdy = 1'b1;
        settle();
        chk("single_no_bypass", iexec_req_vld === 1'b0);
        tick();
        in_vld = 1'b0;
        settle();
        chk("single_vld", iexec_req_vld === 1'b1);
        chk("single_pc", iexec_req_pc === 32'h8000_0000);
        chk("single_ir", iexec_req_ir === 32'h0000_10B7);
        chk("single_opcode", iexec_req_opcode === 7'h37);
        chk("single_count", count === 2'd1);
        tick();
        settle();
        chk("single_after_pop_vld", iexec_req_vld === 1'b0);
        chk("single_after_pop_count", count === 2'd0);

        iexec_req_rdy = 1'b0; in_vld = 1'b1; in_pc = 32'h0; in_ir = 32'h0000_0013;
        settle();
        chk("fill0_in_rdy", in_rdy === 1'b1);
        tick();
        in_pc = 32'h4;
        settle();
        chk("fill1_in_rdy", in_rdy === 1'b1);
        chk("fill1_count", count === 2'd1);
        chk("fill1_head", iexec_req_pc === 32'h0);
        tick();
        in_pc = 32'h8;
        settle();
        chk("fill2_in_rdy", in_rdy === 1'b0);
        chk("fill2_count", count === 2'd2);
        tick();
        in_vld = 1'b0; iexec_req_rdy = 1'b1;
        settle();
        chk("full_rdy_indep", in_rdy === 1'b0);
        chk("full_count", count === 2'd2);
        chk("drain0_pc", iexec_req_pc === 32'h0);
        tick();
        settle();
        chk("drain_in_rdy_back", in_rdy === 1'b1);
        chk("drain1_count", count === 2'd1);
        chk("drain1_pc", iexec_req_pc === 32'h4);
        tick();
        settle();
        chk("drained_vld", iexec_req_vld === 1'b0);
        chk("drained_count", count === 2'd0);

        in_vld = 1'b1; iexec_req_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_pc = 32'h1000 + 32'(4 * i);
            settle();
            if (i == 0) begin
                chk("stream_fill_vld", iexec_req_vld === 1'b0);
            end else begin
                chk("stream_vld", iexec_req_vld === 1'b1);
                chk("stream_pc", iexec_req_pc === 32'h1000 + 32'(4 * (i - 1)));
                chk("stream_count", count === 2'd1);
            end
            tick();
        end
        in_vld = 1'b0;
        settle();
        chk("stream_last_pc", iexec_req_pc === 32'h103C);
        tick();
        settle();
        chk("stream_empty", count === 2'd0);

        iexec_req_rdy = 1'b0; in_vld = 1'b1; in_pc = 32'h200; in_ir = 32'h00A0_8093;
        tick();
        for (int k = 0; k < 5; k++) begin
            in_vld = (k == 0); in_pc = 32'h204; in_ir = 32'h0000_0013;
            settle();
            chk("hold_vld", iexec_req_vld === 1'b1);
            chk("hold_pc", iexec_req_pc === 32'h200);
            chk("hold_ir", iexec_req_ir === 32'h00A0_8093);
            chk("hold_opcode", iexec_req_opcode === 7'h13);
            tick();
        end
        in_vld = 1'b0;
        settle();
        chk("hold_count", count === 2'd2);

        flush = 1'b1; in_vld = 1'b1; in_pc = 32'h300;
        settle();
        chk("flush_in_rdy", in_rdy === 1'b0);
        chk("flush_vld", iexec_req_vld === 1'b0);
        tick();
        flush = 1'b0; in_pc = 32'h100;
        settle();
        chk("post_flush_count", count === 2'd0);
        chk("post_flush_vld", iexec_req_vld === 1'b0);
        chk("post_flush_in_rdy", in_rdy === 1'b1);
        tick();
        in_vld = 1'b0; iexec_req_rdy = 1'b1;
        settle();
        chk("post_flush_head_vld", iexec_req_vld === 1'b1);
        chk("post_flush_head_pc", iexec_req_pc === 32'h100);
        tick();
        settle();
        chk("post_flush_drained", count === 2'd0);

        iexec_req_rdy = 1'b0; in_vld = 1'b1; in_pc = 32'h400;
        tick();
        flush = 1'b1;
        tick();
        settle();
        chk("flush2_count", count === 2'd0);
        chk("flush2_in_rdy", in_rdy === 1'b0);
        tick();
        flush = 1'b0; in_vld = 1'b0;
        settle();
        chk("flush2_done_count", count === 2'd0);
        chk("flush2_done_vld", iexec_req_vld === 1'b0);

        in_vld = 1'b1; in_pc = 32'h500;
        tick();
        in_vld = 1'b0;
        settle();
        chk("mid_pre_count", count === 2'd1);
        rst_n = 1'b0; in_vld = 1'b1; in_pc = 32'h504; iexec_req_rdy = 1'b1;
        settle();
        chk("mid_rst_vld", iexec_req_vld === 1'b0);
        chk("mid_rst_in_rdy", in_rdy === 1'b0);
        tick();
        rst_n = 1'b1; in_vld = 1'b0;
        settle();
        chk("mid_post_count", count === 2'd0);
        chk("mid_post_vld", iexec_req_vld === 1'b0);
        chk("mid_post_in_rdy", in_rdy === 1'b1);
        tick();
        settle();
        chk("mid_stale_vld", iexec_req_vld === 1'b0);
        in_vld = 1'b1; in_pc = 32'h600;
        tick();
        in_vld = 1'b0;
        settle();
        chk("mid_new_vld", iexec_req_vld === 1'b1);
        chk("mid_new_pc", iexec_req_pc === 32'h600);
        tick();
        settle();
        chk("final_count", count === 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exu_iexec_req_fifo.md
Name: exu_iexec_req_fifo

Overview:
- Instruction-execute request queue between the fetch/issue side and the EXU.
- Buffers {pc, ir} pairs from the fetch stage and presents the oldest one to the EXU as the iexec request.
- The EXU handshake (iexec_req_hsk) drives GPR write-enable qualification in the EXU datapath mux.
- Decouples fetch from execute back-pressure and supports a single-cycle flush for redirects.

Parameters:
DEPTH, 2, number of entries; power of two, >= 2
XLEN, 32, pc width (matches RV_XLEN)

Ports:
clk  input  1  core clock
rst_n  input  1  reset, synchronous, active-low
flush  input  1  discard all queued entries (branch/trap redirect)
in_vld  input  1  fetch side has a valid {pc, ir}
in_rdy  output  1  queue can accept an entry this cycle
in_pc  input  XLEN  pc of incoming instruction
in_ir  input  32  incoming instruction word
iexec_req_vld  output  1  head entry valid toward EXU
iexec_req_rdy  input  1  EXU accepts head entry
iexec_req_pc  output  XLEN  head entry pc
iexec_req_ir  output  32  head entry instruction word
iexec_req_opcode  output  7  iexec_req_ir[6:0], feeds EXU opcode select
count  output  clog2(DEPTH)+1  number of valid entries

Behaviour:
Interface:
- One clock domain (clk).
- Reset is synchronous, active-low (rst_n sampled on rising clk edge).

Pointers and state:
- wr_ptr and rd_ptr are clog2(DEPTH)+1 bits wide.
- The MSB is the wrap bit. Pointers wrap naturally modulo 2*DEPTH.
- empty = (wr_ptr == rd_ptr).
- full = (index bits equal) and (wrap bits differ).
- count = wr_ptr - rd_ptr, modulo 2^(clog2(DEPTH)+1).

Handshake:
- push = in_vld & in_rdy.
- pop = iexec_req_vld & iexec_req_rdy (this is iexec_req_hsk).
- in_rdy = rst_n & !flush & !full.
- in_rdy has no combinational dependence on iexec_req_rdy. A full queue does not accept a push even in a cycle that pops.
- iexec_req_vld = rst_n & !flush & !empty.
- iexec_req_vld does not depend on iexec_req_rdy.
- Once asserted, iexec_req_vld and the head payload hold stable until pop or flush.

Latency and data path:
- Push into an empty queue: iexec_req_vld rises the cycle after the push. There is no same-cycle bypass, so minimum latency is 1 cycle.
- Head payload is read from storage[rd_ptr index].
- iexec_req_pc, iexec_req_ir and iexec_req_opcode are don't-care while iexec_req_vld = 0. The checker must not compare them then.
- Storage is not reset.

Simultaneous events:
- Push and pop in the same cycle (not full, not empty): both pointers advance; count is unchanged.
- Push into an empty queue with pop low: count goes 0 -> 1 next cycle.
- flush takes priority over everything. In the flush cycle in_rdy = 0 and iexec_req_vld = 0, so no push or pop occurs. On the next edge rd_ptr <= wr_ptr, so the queue is empty and count = 0.
- flush held for multiple cycles keeps the queue empty. Normal operation resumes in the cycle after flush deasserts.

Reset:
- While rst_n = 0: wr_ptr = rd_ptr = 0, in_rdy = 0, iexec_req_vld = 0, count = 0.
- First cycle after rst_n rises: in_rdy = 1.
- Reset asserted mid-operation drops all entries at the next edge. No pop is signalled during the reset cycle.

Assertions:
- No push when full.
- No pop when empty.
- Head payload stable while iexec_req_vld & !iexec_req_rdy & !flush.
- count <= DEPTH.

Test Plan:
- Reset, then single push pc=0x80000000 ir=0x000010B7 (LUI x1,1) with iexec_req_rdy=1 -> iexec_req_vld rises 1 cycle later with pc 0x80000000, opcode 0x37; pop occurs; count returns to 0.
- Fill: iexec_req_rdy=0, push pc 0x0, 0x4, 0x8 back-to-back (DEPTH=2) -> first two accepted, in_rdy=0 on the third, count=2; set rdy=1 -> pops in order 0x0, 0x4; in_rdy returns to 1 in the cycle after the first pop.
- Streaming: in_vld=1 and iexec_req_rdy=1 for 16 cycles with incrementing pc -> after 1-cycle fill, one pop per cycle, order preserved, count stable at 1, no drops or duplicates.
- Back-pressure stability: head ir=0x00A08093 (ADDI x1,x1,10) held with rdy=0 for 5 cycles -> vld, pc, ir and opcode (0x13) unchanged throughout.
- Flush with count=2 while in_vld=1 -> in_rdy=0 and iexec_req_vld=0 in the flush cycle; next cycle count=0 and vld=0; the subsequent push of pc 0x100 is the first entry popped.
- Reset mid-stream with count=1 -> vld=0 and in_rdy=0 during reset; after release count=0 and the stale entry is never presented.
